// File: rtl/wishbone_uart_rx_if.sv
// Wishbone slave bundle for the UART receiver: request fields from the bus master and response fields from the slave.
interface wishbone_uart_rx_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        stb_i;
  logic        cyc_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output addr_i, data_i, we_i, sel_i, stb_i, cyc_i,
    input  data_o, ack_o
  );

  modport slave (
    input  addr_i, data_i, we_i, sel_i, stb_i, cyc_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/wishbone_uart_rx.sv
// 8N1 UART receiver that feeds a small RX FIFO, which the CPU reads through a Wishbone slave port.
// Optional feature: define UART_RX_IRQ_EN to add a registered irq_o output. Reset is synchronous and active-low (resetn).
module wishbone_uart_rx #(
  parameter int ClkFreq       = 25000000,
  parameter int BoundRate     = 115200,
  parameter int FifoDepthLog2 = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ser_rx,
  wishbone_uart_rx_if.slave   wb
`ifdef UART_RX_IRQ_EN
  ,
  output logic                irq_o
`endif
);

  localparam int Div    = ClkFreq / BoundRate;
  localparam int Half   = Div / 2;
  localparam int Depth  = 2 ** FifoDepthLog2;
  localparam int CntW   = $clog2(Div + 1);
  localparam int CountW = FifoDepthLog2 + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state, state_d;
  logic [1:0]                 sync_q;
  logic                       rx_s;
  logic                       armed;
  logic [CntW-1:0]            cnt;
  logic [2:0]                 bit_cnt;
  logic [7:0]                 shreg;
  logic                       cnt_clr, shift_en, push, ferr_set, arm_clr;

  logic [7:0]                 mem [Depth];
  logic [FifoDepthLog2-1:0]   wr_ptr, rd_ptr;
  logic [CountW-1:0]          count;
  logic                       empty, full, do_push, pop;
  logic                       overrun, frame_err;

  logic                       req, rd_rxdata, wr_status;
  logic                       ack_q;
  logic [31:0]                data_q, rdata;
  logic                       unused_bits;

  assign rx_s = sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], ser_rx};
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // After a framing error the line must go back high before the next start bit is accepted.
  always_ff @(posedge clk) begin
    if (!resetn)      armed <= 1'b0;
    else if (arm_clr) armed <= 1'b0;
    else if (rx_s)    armed <= 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    arm_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s && armed) state_d = START;
      end
      START: begin
        if (cnt == CntW'(Half - 1)) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CntW'(Div - 1)) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == CntW'(Div - 1)) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
          if (rx_s) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
            arm_clr  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (shift_en) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign empty     = (count == '0);
  assign full      = (count == CountW'(Depth));
  assign req       = wb.cyc_i & wb.stb_i & ~ack_q;
  assign rd_rxdata = req & ~wb.we_i & ~wb.addr_i[2];
  assign wr_status = req & wb.we_i & wb.addr_i[2];
  assign pop       = rd_rxdata & ~empty;
  assign do_push   = push & ~full;

  // NOTE: the FIFO storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
    end
  end

  // A flag that is set in the same cycle as a clear-write stays set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push && full)                      overrun <= 1'b1;
      else if (wr_status && wb.data_i[1])    overrun <= 1'b0;
      if (ferr_set)                          frame_err <= 1'b1;
      else if (wr_status && wb.data_i[2])    frame_err <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (!wb.we_i) begin
      if (wb.addr_i[2]) rdata = {16'b0, 8'(count), 4'b0, frame_err, overrun, full, ~empty};
      else if (!empty)  rdata = {23'b0, 1'b1, mem[rd_ptr]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q <= req;
      if (req) data_q <= rdata;
    end
  end

  assign wb.ack_o  = ack_q;
  assign wb.data_o = data_q;

`ifdef UART_RX_IRQ_EN
  always_ff @(posedge clk) begin
    if (!resetn) irq_o <= 1'b0;
    else         irq_o <= ~empty | overrun | frame_err;
  end
`endif

  assign unused_bits = ^{wb.sel_i, wb.addr_i[31:3], wb.addr_i[1:0], wb.data_i[31:3], wb.data_i[0]};

endmodule

// File: tb/tb_wishbone_uart_rx.sv
// Scoreboard bench for wishbone_uart_rx: bus reads queue their expected data, and a monitor checks each acknowledge against that queue.
module tb_wishbone_uart_rx;
  localparam int Div = 10;
  localparam logic [31:0] RXDATA = 32'h0;
  localparam logic [31:0] STATUS = 32'h4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic ser_rx = 1'b1;
  always #5 clk = ~clk;

  wishbone_uart_rx_if wb ();
`ifdef UART_RX_IRQ_EN
  logic irq;
`endif

  wishbone_uart_rx #(
    .ClkFreq(1000000), .BoundRate(100000), .FifoDepthLog2(2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .ser_rx(ser_rx),
    .wb    (wb)
`ifdef UART_RX_IRQ_EN
    ,
    .irq_o (irq)
`endif
  );

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every acknowledge must be a single-cycle pulse that matches the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (wb.ack_o) begin
      check("ack_single_cycle", {31'b0, ack_prev}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        e = sb.pop_front();
        if (e.is_read) check(e.name, wb.data_o, e.data);
      end
    end
    ack_prev = wb.ack_o;
  end

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    wb.cyc_i  = 1'b1;
    wb.stb_i  = 1'b1;
    wb.we_i   = we;
    wb.addr_i = addr;
    wb.data_i = wdata;
    wb.sel_i  = 4'hF;
    e.is_read = ~we;
    e.data    = exp;
    e.name    = name;
    sb.push_back(e);
    @(negedge clk);
    check({name, "_ack_latency"}, {31'b0, wb.ack_o}, 32'h1);
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (Div) @(negedge clk);
    end
    ser_rx = stop;
    repeat (Div) @(negedge clk);
    ser_rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.cyc_i  = 1'b0;
    wb.stb_i  = 1'b0;
    wb.we_i   = 1'b0;
    wb.addr_i = '0;
    wb.data_i = '0;
    wb.sel_i  = '0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    check("reset_ack", {31'b0, wb.ack_o}, 32'h0);
    check("reset_data", wb.data_o, 32'h0);
    repeat (5) @(negedge clk);
    bus(1'b0, STATUS, 32'h0, 32'h0000_0000, "reset_status");

    // Single frame
    send_frame(8'hA5, 1'b1);
    bus(1'b0, STATUS, 32'h0, 32'h0000_0101, "t1_status_one");
    bus(1'b0, RXDATA, 32'h0, 32'h0000_01A5, "t1_rxdata");
    bus(1'b0, STATUS, 32'h0, 32'h0000_0000, "t1_status_empty");

    // Read of an empty FIFO
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0000, "t2_rxdata_empty");
    bus(1'b0, STATUS, 32'h0, 32'h0000_0000, "t2_status_empty");

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    bus(1'b0, STATUS, 32'h0, 32'h0000_0407, "t3_status_full_ovr");
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0101, "t3_pop1");
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0102, "t3_pop2");
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0103, "t3_pop3");
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0104, "t3_pop4");
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0000, "t3_pop_empty");
    bus(1'b0, STATUS, 32'h0, 32'h0000_0004, "t3_status_ovr_only");
    bus(1'b1, STATUS, 32'h2, 32'h0, "t3_clear_ovr");
    bus(1'b0, STATUS, 32'h0, 32'h0000_0000, "t3_status_cleared");

    // Framing error
    send_frame(8'h3C, 1'b0);
    bus(1'b0, STATUS, 32'h0, 32'h0000_0008, "t4_status_ferr");
    bus(1'b1, RXDATA, 32'h4, 32'h0, "t4_write_rxdata_noop");
    bus(1'b0, STATUS, 32'h0, 32'h0000_0008, "t4_status_still_ferr");
    bus(1'b1, STATUS, 32'h4, 32'h0, "t4_clear_ferr");
    bus(1'b0, STATUS, 32'h0, 32'h0000_0000, "t4_status_cleared");

    // Glitch rejection, then a normal frame
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    repeat (30) @(negedge clk);
    bus(1'b0, STATUS, 32'h0, 32'h0000_0000, "t5_status_after_glitch");
    send_frame(8'h55, 1'b1);
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0155, "t5_rxdata");

    // Reset in the middle of a frame with a byte queued and frame_err set
    send_frame(8'h42, 1'b1);
    send_frame(8'h3C, 1'b0);
    bus(1'b0, STATUS, 32'h0, 32'h0000_0109, "t6_status_pre_reset");
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (Div) @(negedge clk);
    ser_rx = 1'b1;
    repeat (25) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("t6_reset_ack", {31'b0, wb.ack_o}, 32'h0);
    check("t6_reset_data", wb.data_o, 32'h0);
    repeat (80) @(negedge clk);
    bus(1'b0, STATUS, 32'h0, 32'h0000_0000, "t6_status_post_reset");
    send_frame(8'h81, 1'b1);
    bus(1'b0, RXDATA, 32'h0, 32'h0000_0181, "t6_rxdata");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
